// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// uart_tx_scheduler: shares one RS-232 TX line between two byte requesters.
// Each frame is start, 8 data bits LSB first, optional even parity, stop.
// Revision: 1.0
// ============================================================================
module uart_tx_scheduler #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              baud_i,
  input  logic              parity_en_i,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic [1:0]        owner_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ALIGN  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              baud_q;
  logic              last_q, last_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              tx_q, tx_d;
  logic [1:0]        owner_q, owner_d;
  logic              busy_q;

  logic              w_tick;
  logic              w_grant0;
  logic              w_grant1;
  logic [DATA_W-1:0] w_sel_data;
  logic [2:0]        w_next_idx;

  assign w_tick     = baud_i & ~baud_q;
  // last_q names the requester served most recently; the other one wins a tie.
  assign w_grant0   = req0_valid_i & (~req1_valid_i | last_q);
  assign w_grant1   = req1_valid_i & (~req0_valid_i | ~last_q);
  assign w_sel_data = w_grant0 ? req0_data_i : req1_data_i;
  assign w_next_idx = cnt_q + 3'd1;

  assign req0_ready_o = (state_q == S_IDLE) & w_grant0 & ~reset_i;
  assign req1_ready_o = (state_q == S_IDLE) & w_grant1 & ~reset_i;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign owner_o      = owner_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    owner_d   = owner_q;
    case (state_q)
      S_IDLE: begin
        // A tick in the acceptance cycle is deliberately not consumed.
        if (w_grant0 | w_grant1) begin
          shreg_d   = w_sel_data;
          par_en_d  = parity_en_i;
          par_bit_d = ^w_sel_data;
          owner_d   = w_grant0 ? 2'b01 : 2'b10;
          last_d    = w_grant1;
          state_d   = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (w_tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          tx_d    = shreg_q[0];
          cnt_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (cnt_q == 3'd7) begin
            if (par_en_q) begin
              tx_d    = par_bit_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            tx_d  = shreg_q[w_next_idx];
            cnt_d = w_next_idx;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          owner_d = 2'b00;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        owner_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      baud_q    <= 1'b0;
      last_q    <= 1'b1;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      cnt_q     <= 3'd0;
      tx_q      <= 1'b1;
      owner_q   <= 2'b00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_i;
      last_q    <= last_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      owner_q   <= owner_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_uart_tx_scheduler: directed self-checking bench for uart_tx_scheduler.
// Revision: 1.0
// ============================================================================
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       baud_i;
  logic       parity_en;
  logic       r0v, r1v;
  logic [7:0] r0d, r1d;
  logic       req0_ready_o, req1_ready_o;
  logic       tx_o, busy_o;
  logic [1:0] owner_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] bcnt;
  int rdy0_cnt = 0;
  int rdy1_cnt = 0;
  int overlap  = 0;
  int grants[$];

  uart_tx_scheduler #(.DATA_W(8)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .baud_i       (baud_i),
    .parity_en_i  (parity_en),
    .req0_valid_i (r0v),
    .req0_data_i  (r0d),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (r1v),
    .req1_data_i  (r1d),
    .req1_ready_o (req1_ready_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .owner_o      (owner_o)
  );

  always #5 clk = ~clk;

  // Baud square wave, period 16 clocks, changed on falling clock edges.
  initial begin
    bcnt   = 4'd0;
    baud_i = 1'b0;
    forever begin
      @(negedge clk);
      bcnt   = bcnt + 4'd1;
      baud_i = bcnt[3];
    end
  end

  always @(posedge clk) begin
    if (req0_ready_o) begin rdy0_cnt++; grants.push_back(0); end
    if (req1_ready_o) begin rdy1_cnt++; grants.push_back(1); end
    if ((req0_ready_o || req1_ready_o) && busy_o) overlap++;
    if (req0_ready_o && req1_ready_o) overlap++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit which, input logic [7:0] data, input bit par, output bit ok);
    @(negedge clk);
    parity_en = par;
    if (!which) begin r0d = data; r0v = 1'b1; end
    else        begin r1d = data; r1v = 1'b1; end
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (which ? req1_ready_o : req0_ready_o) ok = 1'b1;
      @(negedge clk);
    end
    if (!which) r0v = 1'b0;
    else        r1v = 1'b0;
  endtask

  // Returns {stop, [parity], data, start} with bit 0 = first bit on the line.
  task automatic rx_frame(input int nbits, output logic [10:0] bits,
                          output logic [1:0] own, output bit ok);
    ok   = 1'b0;
    bits = '0;
    own  = 2'b00;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (tx_o === 1'b0) ok = 1'b1;
    end
    if (!ok) return;
    repeat (8) @(negedge clk);
    bits[0] = tx_o;
    own     = owner_o;
    for (int i = 1; i < nbits; i++) begin
      repeat (16) @(negedge clk);
      bits[i] = tx_o;
    end
  endtask

  bit         ok;
  logic [10:0] bits;
  logic [1:0]  own;
  int          c0, c1, base, lat, wid;

  initial begin
    reset_i   = 1'b1;
    parity_en = 1'b0;
    r0v = 1'b1; r1v = 1'b0;
    r0d = 8'h00; r1d = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_tx", tx_o, 1);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_owner", owner_o, 0);
    check_eq("rst_ready0", req0_ready_o, 0);
    @(negedge clk);
    r0v     = 1'b0;
    reset_i = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte, parity off
    c0 = rdy0_cnt;
    send(0, 8'hA5, 0, ok);
    check_eq("t1_accept", ok, 1);
    rx_frame(10, bits, own, ok);
    check_eq("t1_seen", ok, 1);
    check_eq("t1_frame", bits, 11'h34A);
    check_eq("t1_owner", own, 2'b01);
    check_eq("t1_busy_stop", busy_o, 1);
    repeat (10) @(negedge clk);
    check_eq("t1_busy_end", busy_o, 0);
    check_eq("t1_owner_end", owner_o, 0);
    check_eq("t1_tx_idle", tx_o, 1);
    check_eq("t1_ready_pulses", rdy0_cnt - c0, 1);

    // Parity on, requester 1
    send(1, 8'h07, 1, ok);
    check_eq("t2_accept", ok, 1);
    rx_frame(11, bits, own, ok);
    check_eq("t2_frame", bits, 11'h60E);
    check_eq("t2_owner", own, 2'b10);
    repeat (10) @(negedge clk);
    check_eq("t2_busy_end", busy_o, 0);
    parity_en = 1'b0;

    // Contention: both requesters valid for four frames
    @(negedge clk);
    base = grants.size();
    c0 = rdy0_cnt; c1 = rdy1_cnt;
    r0d = 8'h11; r1d = 8'h22;
    r0v = 1'b1;  r1v = 1'b1;
    for (int f = 0; f < 4; f++) begin
      rx_frame(10, bits, own, ok);
      check_eq($sformatf("t3_frame%0d", f), bits, (f % 2 == 0) ? 11'h222 : 11'h244);
      check_eq($sformatf("t3_owner%0d", f), own, (f % 2 == 0) ? 2'b01 : 2'b10);
    end
    r0v = 1'b0; r1v = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t3_ngrants", grants.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < grants.size())
        check_eq($sformatf("t3_grant%0d", i), grants[base + i], i % 2);
    check_eq("t3_rdy0", rdy0_cnt - c0, 2);
    check_eq("t3_rdy1", rdy1_cnt - c1, 2);

    // Acceptance coincident with a tick
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (bcnt == 4'd7) ok = 1'b1;
    end
    @(negedge clk);
    r0d = 8'hA5; r0v = 1'b1;
    #1;
    check_eq("t4_ready", req0_ready_o, 1);
    @(posedge clk);
    @(negedge clk);
    r0v = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (tx_o == 1'b0) break;
    end
    check_eq("t4_latency", lat, 16);
    wid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      wid++;
      if (tx_o != 1'b0) break;
    end
    check_eq("t4_start_width", wid, 16);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (busy_o == 1'b0) ok = 1'b1;
    end
    check_eq("t4_done", ok, 1);
    repeat (4) @(negedge clk);

    // Reset in the middle of data bit 3
    send(0, 8'h00, 0, ok);
    check_eq("t5_accept", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (tx_o === 1'b0) ok = 1'b1;
    end
    repeat (8 + 16 * 4) @(negedge clk);
    check_eq("t5_pre_tx", tx_o, 0);
    reset_i = 1'b1;
    #1;
    check_eq("t5_rst_tx", tx_o, 1);
    check_eq("t5_rst_busy", busy_o, 0);
    check_eq("t5_rst_owner", owner_o, 0);
    @(negedge clk);
    reset_i = 1'b0;
    r0d = 8'h3C; r1d = 8'h55;
    r0v = 1'b1;  r1v = 1'b1;
    #1;
    check_eq("t5_first_ready0", req0_ready_o, 1);
    check_eq("t5_first_ready1", req1_ready_o, 0);
    @(negedge clk);
    r0v = 1'b0; r1v = 1'b0;
    rx_frame(10, bits, own, ok);
    check_eq("t5_frame", bits, 11'h278);
    check_eq("t5_owner", own, 2'b01);
    repeat (10) @(negedge clk);
    check_eq("t5_busy_end", busy_o, 0);

    // Requester 1 raises and drops valid while busy
    c1 = rdy1_cnt;
    send(0, 8'h11, 0, ok);
    check_eq("t6_accept", ok, 1);
    fork
      rx_frame(10, bits, own, ok);
      begin
        repeat (20) @(negedge clk);
        r1d = 8'h99; r1v = 1'b1;
        repeat (5) @(negedge clk);
        r1v = 1'b0;
      end
    join
    check_eq("t6_frame", bits, 11'h222);
    repeat (50) @(negedge clk);
    check_eq("t6_rdy1", rdy1_cnt - c1, 0);
    check_eq("t6_busy", busy_o, 0);
    check_eq("t6_tx_idle", tx_o, 1);

    check_eq("overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares one RS-232 transmit line between two byte producers. Consumes the baud output of `baudrate_generator` (level signal), turns its rising edges into bit ticks, arbitrates round-robin between two valid/ready requesters, and serialises the granted byte as an 8-bit LSB-first frame with optional even parity. Sits beside `baudrate_generator` in the `rs232` top, between the requesters and the TX pin.

## Interface
- `DATA_W`, 8, data bits per frame (fixed at 8 for this release; bit counter is 3 bits).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `baud_in`  in  1  baud output of `baudrate_generator`; one bit period = one rising edge to the next.
- `parity_en`  in  1  1 = append even parity bit; sampled at acceptance.
- `req0_valid`  in  1  requester 0 has a byte.
- `req0_data`  in  8  requester 0 byte.
- `req0_ready`  out  1  requester 0 byte accepted this cycle (valid & ready).
- `req1_valid`, `req1_data`, `req1_ready`: as requester 0.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  frame in progress (state != IDLE).
- `owner`  out  2  one-hot owner of current frame; 2'b00 in IDLE.

## Operation
- Tick: `baud_q` register (reset 0) holds previous `baud_in`; `tick = baud_in & ~baud_q`. Ticks outside ALIGN/START/DATA/PARITY/STOP are ignored.
- Arbitration (IDLE only): `last` pointer (reset = 1, so requester 0 wins first). Both valid: grant the one != `last`. Single valid: grant it. `reqN_ready` is combinational = (state==IDLE) & granted N & reqN_valid; zero in every other state and during reset.
- Acceptance (valid & ready): capture data into `shreg`, capture `parity_en` into `par_q`, compute even parity (XOR of 8 bits), set `owner`, update `last`, go to ALIGN. Exactly one requester accepted per frame.
- FSM, all transitions only on `tick`:
  - ALIGN: tx<=0, -> START.
  - START: tx<=data[0], cnt<=0, -> DATA.
  - DATA: if cnt==7: tx<=parity, -> PARITY when `par_q`, else tx<=1, -> STOP; otherwise tx<=data[cnt+1], cnt<=cnt+1.
  - PARITY: tx<=1, -> STOP.
  - STOP: -> IDLE, owner<=00; tx stays 1.
- Frame = start, 8 data LSB first, [parity], stop; each bit exactly one tick period.
- Requester data/valid changes after acceptance have no effect on the current frame; a requester with valid held stays pending until granted.
- `busy`, `owner` registered from state.

## Timing
- Reset values: tx=1, busy=0, owner=00, req0_ready=req1_ready=0, state IDLE, cnt=0, `last`=1, baud_q=0. Reset is asynchronous: mid-frame assertion forces tx=1 immediately, frame aborted, no data retained.
- Acceptance to start bit: tx falls on the first tick strictly after the acceptance cycle; a tick in the acceptance cycle itself is not consumed.
- Frame occupancy: stop bit ends on the tick leaving STOP; earliest next acceptance is the following clock in IDLE. Back-to-back frames therefore have an alignment gap ≤ 1 bit period plus one clock.
- `baud_in` high at reset release: no tick until its next rising edge.
- busy rises the cycle after acceptance; falls the cycle after the STOP-exit tick.
- `baud_in` assumed synchronous to `clk` (generated in the same domain); no synchroniser.

## Test plan
- Single byte, parity off: `baud_in` square wave period 16 clk, req0 sends 8'hA5 -> req0_ready 1 cycle, tx = 0,1,0,1,0,0,1,0,1,1 each held 16 clk, owner=01 during frame, busy drops after stop.
- Parity on: req1 sends 8'h07 with parity_en=1 -> 11-bit frame, parity bit 1, owner=10.
- Contention: both valid continuously with 8'h11/8'h22 for 4 frames -> grant order 0,1,0,1; each ready pulses once per frame; frames never overlap.
- Tick coincident with acceptance: align req0_valid so acceptance falls on a tick cycle -> start bit begins at the next tick, full 16-clk width.
- Reset mid-frame: assert reset during data bit 3 -> tx=1 same cycle, busy=0, owner=00; after release req0 byte 8'h3C transmits complete and correct, req0 granted first.
- Valid dropped while busy: req1 raises then drops valid during req0 frame -> req1 never acknowledged, line returns idle after req0 stop bit.
